// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access types,
// FSM states and the access-size decode used by the lane logic.
package lsu_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Encodings outside the five defined ones fall back to a word access.
    function automatic access_size_e size_of(input logic [2:0] mt);
        access_size_e sz;
        case (mt)
            MT_B, MT_BU: sz = SZ_BYTE;
            MT_H, MT_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic shared by both directions: store strobes and
// replicated write data, load extraction with sign/zero extension, alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
        logic signed [31:0] v;
        v = is_signed ? $signed({{24{b[7]}}, b}) : $signed({24'd0, b});
        return v;
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
        logic signed [31:0] v;
        v = is_signed ? $signed({{16{h[15]}}, h}) : $signed({16'd0, h});
        return v;
    endfunction

    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;
    access_size_e sz;

    always_comb begin
        sz         = size_of(mem_type);
        rd_byte    = rdata[{addr_lo, 3'b000} +: 8];
        rd_half    = rdata[{addr_lo[1], 4'b0000} +: 16];
        wstrb      = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (sz)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = ext_byte(rd_byte, mem_type != MT_BU);
            end
            SZ_HALF: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                load_data  = ext_half(rd_half, mem_type != MT_HU);
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one bus access per instruction over a
// req/ack handshake, stalls upstream until done, and returns extended loads.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_we_m,
    input  logic        mem_re_m,
    input  logic [2:0]  mem_type_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] rd2_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic [31:0] load_data_w,
    output logic        load_valid_w,
    output logic        misalign_fault,
    output logic        bus_fault
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [3:0]       dmem_wstrb_q, dmem_wstrb_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic [2:0]       type_q, type_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             misalign_q, misalign_d;
    logic             bus_fault_q, bus_fault_d;

    logic [2:0]  al_type;
    logic [1:0]  al_addr;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misaligned;
    logic        req_present;
    logic        issue;

    // Idle decodes the incoming instruction; while waiting, the captured access drives extraction.
    assign al_type = (state_q == ST_IDLE) ? mem_type_m : type_q;
    assign al_addr = (state_q == ST_IDLE) ? alu_result_m[1:0] : addr_lo_q;

    lsu_align u_align (
        .mem_type   (al_type),
        .addr_lo    (al_addr),
        .store_data (rd2_m),
        .rdata      (dmem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    assign req_present = mem_we_m | mem_re_m;
    assign issue       = (state_q == ST_IDLE) && req_present && !al_misaligned;
    assign stall_m     = rst_n & (issue | (state_q == ST_WAIT));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wstrb_d = dmem_wstrb_q;
        dmem_wdata_d = dmem_wdata_q;
        type_d       = type_q;
        addr_lo_d    = addr_lo_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        bus_fault_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_present && al_misaligned) begin
                    misalign_d = 1'b1;
                end else if (issue) begin
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = mem_we_m;
                    dmem_addr_d  = {alu_result_m[31:2], 2'b00};
                    dmem_wstrb_d = mem_we_m ? al_wstrb : 4'b0000;
                    dmem_wdata_d = al_wdata;
                    type_d       = mem_type_m;
                    addr_lo_d    = alu_result_m[1:0];
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // An ack arriving on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q) begin
                        load_data_d  = al_load;
                        load_valid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    dmem_req_d  = 1'b0;
                    bus_fault_d = 1'b1;
                    load_data_d = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d      = '0;
                dmem_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wstrb_q <= '0;
            dmem_wdata_q <= '0;
            type_q       <= '0;
            addr_lo_q    <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wstrb_q <= dmem_wstrb_d;
            dmem_wdata_q <= dmem_wdata_d;
            type_q       <= type_d;
            addr_lo_q    <= addr_lo_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            bus_fault_q  <= bus_fault_d;
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign load_data_w    = load_data_q;
    assign load_valid_w   = load_valid_q;
    assign misalign_fault = misalign_q;
    assign bus_fault      = bus_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver emulates the pipeline and a bus
// slave, expected events are queued at issue and a monitor pops them.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    localparam int TO = 4;
    localparam int EV_REQ  = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_MIS  = 2;
    localparam int EV_BUSF = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_we_m, mem_re_m;
    logic [2:0]  mem_type_m;
    logic [31:0] alu_result_m, rd2_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_m;
    logic [31:0] load_data_w;
    logic        load_valid_w, misalign_fault, bus_fault;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_we_m(mem_we_m), .mem_re_m(mem_re_m), .mem_type_m(mem_type_m),
        .alu_result_m(alu_result_m), .rd2_m(rd2_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .load_data_w(load_data_w), .load_valid_w(load_valid_w),
        .misalign_fault(misalign_fault), .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 1;
    logic [31:0] slv_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] t);
        case (t)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Reference: lanes covered by the access, store data repeated per lane, load value by bytes.
    function automatic logic [3:0] model_strb(input int sz, input int off);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < sz; k++) s[off + k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input int off, input logic [31:0] rd);
        longint v;
        int     sz;
        logic [63:0] bits;
        sz = size_bytes(t);
        v  = 0;
        for (int k = 0; k < sz; k++) v += longint'(rd[8*(off + k) +: 8]) << (8 * k);
        if ((t == 3'b000 || t == 3'b001) && v >= (longint'(1) << (8 * sz - 1)))
            v -= (longint'(1) << (8 * sz));
        bits = v;
        return bits[31:0];
    endfunction

    // Bus slave: acks on the ack_delay-th cycle of a request; ack_delay 0 never acks.
    initial begin
        int w;
        w = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            if (!rst_n || !dmem_req) begin
                w = 0;
                dmem_ack = 1'b0;
            end else begin
                w++;
                if (ack_delay != 0 && w == ack_delay) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = slv_rdata;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                end
            end
        end
    end

    task automatic expect_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d actual=present required=none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == kind) begin
                if (kind == EV_REQ) begin
                    chk("req_addr", dmem_addr, e.addr);
                    chk("req_we", {31'd0, dmem_we}, {31'd0, e.we});
                    chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, e.strb});
                    if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
                end else if (kind == EV_LOAD) begin
                    chk("load_data", load_data_w, e.ldata);
                end else if (kind == EV_BUSF) begin
                    chk("busf_load_data", load_data_w, 32'd0);
                end
            end
        end
    endtask

    // Monitor: every visible DUT event must match the head of the expectation queue.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) begin
                if (dmem_req && !prev_req) expect_event(EV_REQ);
                if (load_valid_w)          expect_event(EV_LOAD);
                if (misalign_fault)        expect_event(EV_MIS);
                if (bus_fault)             expect_event(EV_BUSF);
            end
            prev_req = dmem_req;
        end
    end

    task automatic do_access(input logic we, input logic re, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] d, input int dly,
                             input logic [31:0] rd, input string tag);
        int   sz, off, exp_stall, n;
        bit   done;
        exp_t e;
        @(negedge clk);
        #1;
        ack_delay = dly;
        slv_rdata = rd;
        mem_we_m = we;
        mem_re_m = re;
        mem_type_m = t;
        alu_result_m = a;
        rd2_m = d;
        sz  = size_bytes(t);
        off = int'(a[1:0]);
        if (!(we || re)) begin
            exp_stall = 0;
        end else if ((off % sz) != 0) begin
            e = '{kind: EV_MIS, addr: 0, we: 0, strb: 0, wdata: 0, ldata: 0};
            exp_q.push_back(e);
            exp_stall = 0;
        end else begin
            e = '{kind: EV_REQ, addr: {a[31:2], 2'b00}, we: we,
                  strb: we ? model_strb(sz, off) : 4'b0000, wdata: model_wdata(sz, d), ldata: 0};
            exp_q.push_back(e);
            if (dly == 0) begin
                e = '{kind: EV_BUSF, addr: 0, we: 0, strb: 0, wdata: 0, ldata: 0};
                exp_q.push_back(e);
            end else if (!we) begin
                e = '{kind: EV_LOAD, addr: 0, we: 0, strb: 0, wdata: 0, ldata: model_load(t, off, rd)};
                exp_q.push_back(e);
            end
            exp_stall = 1 + ((dly != 0) ? dly : TO);
        end
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            if (stall_m) n++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_stall_bound actual=stuck required=release", tag);
        end else begin
            chk({tag, "_stall"}, n, exp_stall);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        mem_we_m = 1'b0;
        mem_re_m = 1'b1;
        mem_type_m = MT_W;
        alu_result_m = 32'h100;
        rd2_m = 32'h1234_5678;
        repeat (3) @(posedge clk);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_load_data", load_data_w, 32'd0);
        chk("rst_load_valid", {31'd0, load_valid_w}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_fault}, 32'd0);
        chk("rst_bus_fault", {31'd0, bus_fault}, 32'd0);
        chk("rst_stall", {31'd0, stall_m}, 32'd0);
        mem_re_m = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;

        do_access(1, 0, MT_B,  32'h103, 32'h0000_00A5, 2, 32'h0,         "sb");
        do_access(0, 1, MT_B,  32'h202, 32'h0,         1, 32'h0080_0000, "lb");
        do_access(0, 1, MT_BU, 32'h202, 32'h0,         1, 32'h0080_0000, "lbu");
        do_access(0, 1, MT_H,  32'h301, 32'h0,         1, 32'h0,         "lh_mis");
        do_access(0, 1, MT_W,  32'h302, 32'h0,         1, 32'h0,         "lw_mis");
        do_access(0, 1, MT_W,  32'h400, 32'h0,         0, 32'h0,         "lw_timeout");
        do_access(0, 1, MT_H,  32'h502, 32'h0,         TO, 32'h8001_7FFF, "lh_ack_at_limit");
        do_access(1, 1, MT_H,  32'h602, 32'hBEEF_1234, 1, 32'h0,         "both_is_store");
        do_access(0, 1, 3'b111, 32'h700, 32'h0,        3, 32'h9ABC_DEF0, "undef_type_load");

        // Reset while the access is still waiting for ack.
        @(negedge clk);
        #1;
        ack_delay = 0;
        mem_we_m = 1'b0;
        mem_re_m = 1'b1;
        mem_type_m = MT_W;
        alu_result_m = 32'h40;
        e = '{kind: EV_REQ, addr: 32'h40, we: 1'b0, strb: 4'b0000, wdata: 0, ldata: 0};
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall_m}, 32'd0);
        chk("midrst_pending", exp_q.size(), 32'd0);
        mem_re_m = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        do_access(1, 0, MT_W, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, "sw_after_rst");

        do_access(0, 1, MT_W, 32'h20, 32'h0,         1, 32'h1234_5678, "b2b_lw");
        do_access(1, 0, MT_W, 32'h24, 32'hCAFE_F00D, 1, 32'h0,         "b2b_sw");

        for (int i = 0; i < 150; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom_range(0, TO), $urandom, "rnd");
        end

        do_access(0, 0, MT_W, 32'h0, 32'h0, 1, 32'h0, "final_bubble");
        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
